// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
//   Shared definitions for the vending machine payment path: coin encodings,
//   coin cent values, the payment controller state enum and the default
//   datapath widths. The snack selector and the hopper model use the same
//   package, so the coin and price encodings stay consistent across blocks.
// ---------------------------------------------------------------------------
package vend_pkg;

    localparam int PRICE_W        = 9;    // price in cents, max 400
    localparam int CREDIT_W       = 10;   // credit register width in cents
    localparam int MAX_CREDIT_DEF = 500;  // default credit ceiling

    localparam int CENTS_5   = 5;
    localparam int CENTS_10  = 10;
    localparam int CENTS_25  = 25;
    localparam int CENTS_100 = 100;

    // Coin codes on coin_value / change_coin (the hopper never pays 100c)
    typedef enum logic [1:0] {
        COIN_5   = 2'b00,
        COIN_10  = 2'b01,
        COIN_25  = 2'b10,
        COIN_100 = 2'b11
    } coin_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_VEND    = 2'b10,
        ST_CHANGE  = 2'b11
    } state_e;

    // Cent value of a coin code, sized to the credit register
    function automatic logic [CREDIT_W-1:0] coin_cents(input logic [1:0] code);
        logic [CREDIT_W-1:0] value;
        case (code)
            2'b00:   value = CREDIT_W'(CENTS_5);
            2'b01:   value = CREDIT_W'(CENTS_10);
            2'b10:   value = CREDIT_W'(CENTS_25);
            default: value = CREDIT_W'(CENTS_100);
        endcase
        return value;
    endfunction

endpackage

// File: rtl/vend_payment_ctrl_if.sv
// ---------------------------------------------------------------------------
// vend_payment_ctrl_if
//   Bundles the payment controller's machine-side signals.
//   slave  : the payment controller (consumes price/coins/keypad/hopper acks)
//   master : the rest of the machine (selector, coin mech, keypad, motor,
//            hopper) which drives the requests and observes the responses.
//   Signals: price, coin_valid, coin_value, coin_accept, coin_reject,
//            vend_req, cancel, short_funds, vend_out, vend_done,
//            change_valid, change_coin, change_ack, credit, busy.
// ---------------------------------------------------------------------------
interface vend_payment_ctrl_if;
    import vend_pkg::*;

    logic [PRICE_W-1:0]  price;
    logic                coin_valid;
    logic [1:0]          coin_value;
    logic                coin_accept;
    logic                coin_reject;
    logic                vend_req;
    logic                cancel;
    logic                short_funds;
    logic                vend_out;
    logic                vend_done;
    logic                change_valid;
    logic [1:0]          change_coin;
    logic                change_ack;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport slave (
        input  price, coin_valid, coin_value, vend_req, cancel, vend_done, change_ack,
        output coin_accept, coin_reject, short_funds, vend_out,
               change_valid, change_coin, credit, busy
    );

    modport master (
        output price, coin_valid, coin_value, vend_req, cancel, vend_done, change_ack,
        input  coin_accept, coin_reject, short_funds, vend_out,
               change_valid, change_coin, credit, busy
    );

endinterface

// File: rtl/change_coin_pick.sv
// ---------------------------------------------------------------------------
// change_coin_pick
//   Combinational greedy change selector: picks the largest hopper coin
//   (25c, 10c, 5c) that does not exceed the remaining credit.
//   Ports:
//     credit     in   remaining credit in cents
//     coin_code  out  hopper coin code (never COIN_100)
//     coin_cents out  cent value of the chosen coin, 0 when none
//     none       out  credit below 5c, nothing left to pay
// ---------------------------------------------------------------------------
module change_coin_pick
    import vend_pkg::*;
(
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          coin_code,
    output logic [CREDIT_W-1:0] coin_cents,
    output logic                none
);

    // Greedy choice, largest coin first; the leftover 1-4c residue is
    // reported as "none" so the controller can forfeit it and go idle.
    always_comb begin
        coin_code  = COIN_5;
        coin_cents = '0;
        none       = 1'b1;
        if (credit >= CREDIT_W'(CENTS_25)) begin
            coin_code  = COIN_25;
            coin_cents = CREDIT_W'(CENTS_25);
            none       = 1'b0;
        end else if (credit >= CREDIT_W'(CENTS_10)) begin
            coin_code  = COIN_10;
            coin_cents = CREDIT_W'(CENTS_10);
            none       = 1'b0;
        end else if (credit >= CREDIT_W'(CENTS_5)) begin
            coin_code  = COIN_5;
            coin_cents = CREDIT_W'(CENTS_5);
            none       = 1'b0;
        end
    end

endmodule

// File: rtl/vend_payment_ctrl.sv
// ---------------------------------------------------------------------------
// vend_payment_ctrl
//   Payment side of the vending machine. Accumulates coins as credit, vends
//   when credit covers the selected price, then pays change through the
//   hopper handshake one coin at a time.
//   Ports:
//     clk    in  single clock, rising edge
//     rst_n  in  synchronous active-low reset
//     bus    slave modport of vend_payment_ctrl_if (coins, keypad, motor,
//            hopper, credit display, busy)
//   Parameter:
//     MAX_CREDIT  coin rejected if credit + coin would exceed this
//   Optional feature:
//     ESCROW_REFUND_EN  when defined, cancel in COLLECT refunds the credit
//                       through the change path; otherwise cancel is ignored.
// ---------------------------------------------------------------------------
module vend_payment_ctrl
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = MAX_CREDIT_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    vend_payment_ctrl_if.slave  bus
);

    localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] MIN_CHANGE = CREDIT_W'(CENTS_5);

    state_e              state;
    logic [CREDIT_W-1:0] credit_r;
    logic                coin_accept_r;
    logic                coin_reject_r;
    logic                short_funds_r;
    logic                vend_out_r;
    logic                change_valid_r;
    logic [1:0]          change_coin_r;

    logic [CREDIT_W-1:0] price_ext;
    logic                vend_ok;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                cancel_hit;
    logic [1:0]          pick_code;
    logic [CREDIT_W-1:0] pick_cents;
    logic                pick_none;

    change_coin_pick u_pick (
        .credit     (credit_r),
        .coin_code  (pick_code),
        .coin_cents (pick_cents),
        .none       (pick_none)
    );

    // Purchase and coin decisions all look at the registered credit, so a coin
    // arriving in the same cycle as a buy never helps pay for that buy.
    always_comb begin
        price_ext = CREDIT_W'(bus.price);
        vend_ok   = bus.vend_req && (bus.price != '0) && (credit_r >= price_ext);
        coin_sum  = {1'b0, credit_r} + {1'b0, coin_cents(bus.coin_value)};
        coin_fits = (coin_sum <= MAX_SUM);
    end

`ifdef ESCROW_REFUND_EN
    // A refund only makes sense while money is being collected.
    assign cancel_hit = bus.cancel && (state == ST_COLLECT);
`else
    logic unused_cancel;
    assign unused_cancel = bus.cancel;
    assign cancel_hit    = 1'b0;
`endif

    // Main controller. The price is captured by deducting it from credit at
    // the moment the buy is accepted, so later price changes cannot affect the
    // transaction. Pulses default low every cycle; change_valid drops for one
    // cycle after each hopper ack before the next coin is requested.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            credit_r       <= '0;
            coin_accept_r  <= 1'b0;
            coin_reject_r  <= 1'b0;
            short_funds_r  <= 1'b0;
            vend_out_r     <= 1'b0;
            change_valid_r <= 1'b0;
            change_coin_r  <= '0;
        end else begin
            coin_accept_r <= 1'b0;
            coin_reject_r <= 1'b0;
            short_funds_r <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (bus.vend_req && !vend_ok) begin
                        short_funds_r <= 1'b1;
                    end
                    if (vend_ok) begin
                        credit_r      <= credit_r - price_ext;
                        vend_out_r    <= 1'b1;
                        coin_reject_r <= bus.coin_valid;
                        state         <= ST_VEND;
                    end else if (cancel_hit) begin
                        coin_reject_r <= bus.coin_valid;
                        if (credit_r >= MIN_CHANGE) begin
                            state <= ST_CHANGE;
                        end else begin
                            credit_r <= '0;
                            state    <= ST_IDLE;
                        end
                    end else if (bus.coin_valid) begin
                        if (coin_fits) begin
                            credit_r      <= coin_sum[CREDIT_W-1:0];
                            coin_accept_r <= 1'b1;
                            state         <= ST_COLLECT;
                        end else begin
                            coin_reject_r <= 1'b1;
                        end
                    end
                end
                ST_VEND: begin
                    coin_reject_r <= bus.coin_valid;
                    if (bus.vend_done) begin
                        vend_out_r <= 1'b0;
                        if (credit_r >= MIN_CHANGE) begin
                            state <= ST_CHANGE;
                        end else begin
                            credit_r <= '0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_CHANGE: begin
                    coin_reject_r <= bus.coin_valid;
                    if (change_valid_r) begin
                        // Credit is frozen while a coin is requested, so the
                        // picker still describes the coin on change_coin.
                        if (bus.change_ack) begin
                            credit_r       <= credit_r - pick_cents;
                            change_valid_r <= 1'b0;
                            change_coin_r  <= '0;
                        end
                    end else if (pick_none) begin
                        credit_r <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        change_valid_r <= 1'b1;
                        change_coin_r  <= pick_code;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.coin_accept  = coin_accept_r;
    assign bus.coin_reject  = coin_reject_r;
    assign bus.short_funds  = short_funds_r;
    assign bus.vend_out     = vend_out_r;
    assign bus.change_valid = change_valid_r;
    assign bus.change_coin  = change_coin_r;
    assign bus.credit       = credit_r;
    assign bus.busy         = (state == ST_VEND) || (state == ST_CHANGE);

endmodule
